sn_window_decoder: RTL and testbench
====================================

Name: sn_window_decoder

Overview:
- Downstream stage of the stochastic multiplier. Consumes its serial stochastic output bit (SN_Bit_Out style stream).
- Counts 1s over a fixed window of 2^WIN_LOG2 qualified bits. Presents the unipolar count and the bipolar value through a valid/ready result port.
- Replaces the ad-hoc 3-bit window counter. The count is wide enough that a full window of 1s never wraps.

Parameters:
- WIN_LOG2, 4, window length = 2^WIN_LOG2 accepted bits. Legal range 2..10.
- CNT_W, WIN_LOG2+1, width of the ones count (0..2^WIN_LOG2 inclusive). Derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. Synchronous and active-high, despite the name.
- enable  in  1  level. 1 = accumulate; 0 = abort the window and idle.
- clear  in  1  one-cycle pulse. Drops the partial window, the pending result and overrun.
- sn_bit  in  1  stochastic stream bit.
- sn_valid  in  1  sn_bit is sampled only when sn_valid=1 and state=ACCUM.
- res_count  out  CNT_W  number of 1s in the completed window (unsigned).
- res_bipolar  out  CNT_W+1  signed value 2*res_count - 2^WIN_LOG2.
- res_valid  out  1  result held until accepted.
- res_ready  in  1  consumer accepts when res_valid & res_ready.
- overrun  out  1  sticky. A completed result overwrote an unaccepted one.
- busy  out  1  state==ACCUM.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=IDLE.
  - bit_cnt=0, ones_cnt=0.
  - res_count=0, res_bipolar=0, res_valid=0, overrun=0, busy=0.
- Reset overrides all other inputs, including mid-window.
- Priority each edge: rst_n > clear > enable > data.
- clear:
  - state=IDLE, counters=0, res_valid=0, overrun=0.
  - res_count and res_bipolar keep their last value.
- FSM states IDLE and ACCUM:
  - IDLE -> ACCUM when enable=1 (no clear). No bit is sampled on that edge.
  - ACCUM -> IDLE when enable=0. Partial-window counters are zeroed and that partial window is discarded.
  - A pending result (res_valid) survives enable=0.
- Accumulation in ACCUM with sn_valid=1:
  - bit_cnt += 1 (WIN_LOG2 bits, wraps naturally).
  - ones_cnt += sn_bit.
- Window completion: in ACCUM with sn_valid=1 and bit_cnt == 2^WIN_LOG2-1.
  - The same edge loads res_count = ones_cnt + sn_bit and res_bipolar = 2*(ones_cnt+sn_bit) - 2^WIN_LOG2, sign-correct in CNT_W+1 bits.
  - The same edge sets res_valid=1.
  - The same edge sets bit_cnt=0 and ones_cnt=0. The next window starts on the following accepted bit, with no bubble.
  - Latency: result is visible in the cycle after the edge that samples the last bit.
- Handshake:
  - res_valid drops on an edge where res_ready=1, unless a new completion occurs on that same edge.
  - Completion with res_valid=1 and res_ready=0: new result overwrites the old one, overrun<=1, res_valid stays 1.
  - Completion with res_valid=1 and res_ready=1 on the same edge: old result consumed, new one loaded, res_valid stays 1, overrun unchanged.
  - Outputs are stable while res_valid=1 and res_ready=0 (no completion).
- Boundaries:
  - All-ones window gives res_count=2^WIN_LOG2 and res_bipolar=+2^WIN_LOG2. No overflow flag is needed.
  - All-zeros window gives 0 and -2^WIN_LOG2.
  - sn_valid=0 cycles are ignored; window length is counted in accepted bits, not cycles.
  - clear and completion on the same edge: clear wins and no result is produced.

Decomposition:
- Package sn_pkg holds:
  - state enum (IDLE, ACCUM);
  - function bipolar_of(count, win_log2);
  - shared constant for the default WIN_LOG2.
- One natural sub-module, sn_window_counter: bit_cnt, ones_cnt, terminal flag, sync zeroing.
- Top level holds the FSM, result registers and handshake.

Test Plan (WIN_LOG2=4):
1. Reset, enable=1, 16 accepted bits of 1 with res_ready=0 -> res_valid=1 the cycle after the 16th bit; res_count=16; res_bipolar=+16; overrun=0.
2. Pattern 1010... over 16 bits -> res_count=8, res_bipolar=0. All zeros -> res_count=0, res_bipolar=-16.
3. sn_valid toggling every cycle, sn_bit=1 -> completion only after 32 cycles (16 accepted); res_count=16.
4. res_ready held 0 across two windows (12 ones, then 4 ones) -> res_count=4, res_bipolar=-8, overrun=1. Pulse clear -> res_valid=0, overrun=0.
5. res_ready=1 on the exact completion edge of window 2 -> res_valid stays 1, window-2 value shown, overrun=0.
6. Drop enable after 7 bits, re-enable, send 16 ones -> res_count=16 (partial discarded). Repeat with rst_n pulsed at bit 9 -> all outputs 0; the next window counts from zero.

Source files
------------

// File: rtl/sn_window_decoder_pkg.sv
// Shared types and helpers for the stochastic window decoder.
// Holds the FSM state enum, default window size and bipolar mapping.
package sn_pkg;

  localparam int SN_WIN_LOG2_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sn_state_e;

  // 2*count - 2^win_log2, wide enough for win_log2 up to 10
  function automatic logic [11:0] bipolar_of(
    input logic [10:0] count,
    input int          win_log2
  );
    logic [11:0] w;
    w = 12'd1 << win_log2;
    return {count, 1'b0} - w;
  endfunction

endpackage

// File: rtl/sn_window_decoder_if.sv
// Result port of the window decoder: count, bipolar value, valid/ready.
// master = decoder side, slave = consumer side.
interface sn_window_decoder_if #(
  parameter int WIN_LOG2 = 4
);
  localparam int CNT_W = WIN_LOG2 + 1;

  logic [CNT_W-1:0]  res_count;
  logic signed [CNT_W:0] res_bipolar;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_count,
    output res_bipolar,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_count,
    input  res_bipolar,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/sn_window_decoder_counter.sv
// Window counter: accepted-bit count, ones count and terminal flag.
// Ports: clk, rst_n (sync active-high), zero, inc, bit_in, ones_cnt, last.
module sn_window_counter #(
  parameter int WIN_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zero,
  input  logic              inc,
  input  logic              bit_in,
  output logic [WIN_LOG2:0] ones_cnt,
  output logic              last
);

  logic [WIN_LOG2-1:0] bit_cnt;

  assign last = &bit_cnt;

  always_ff @(posedge clk) begin
    if (rst_n || zero) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (inc) begin
      bit_cnt  <= bit_cnt + 1'b1;
      ones_cnt <= ones_cnt + {{WIN_LOG2{1'b0}}, bit_in};
    end
  end

endmodule

// File: rtl/sn_window_decoder.sv
// Counts ones over 2^WIN_LOG2 accepted stochastic bits, emits result.
// Ports: clk, rst_n (sync active-high), enable, clear, sn_bit, sn_valid, res, overrun, busy.
module sn_window_decoder
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = SN_WIN_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 sn_bit,
  input  logic                 sn_valid,
  sn_window_decoder_if.master  res,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = WIN_LOG2 + 1;

  sn_state_e        state;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] win_sum;
  logic             last;
  logic             accept;
  logic             done;
  logic             zero;

  assign accept  = (state == ACCUM) && enable && sn_valid;
  assign done    = accept && last;
  assign win_sum = ones_cnt + {{(CNT_W-1){1'b0}}, sn_bit};
  // abort, completion and clear all restart the window
  assign zero    = clear || done
                || ((state == ACCUM) && !enable);
  assign busy    = (state == ACCUM);

  sn_window_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .zero     (zero),
    .inc      (accept),
    .bit_in   (sn_bit),
    .ones_cnt (ones_cnt),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state           <= IDLE;
      res.res_count   <= '0;
      res.res_bipolar <= '0;
      res.res_valid   <= 1'b0;
      overrun         <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      res.res_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (res.res_valid && res.res_ready)
        res.res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable)
            state <= ACCUM;
        end
        ACCUM: begin
          if (!enable) begin
            state <= IDLE;
          end else if (done) begin
            res.res_count   <= win_sum;
            res.res_bipolar <= (CNT_W+1)'(
              bipolar_of(11'(win_sum), WIN_LOG2));
            res.res_valid   <= 1'b1;
            // old result unconsumed on this edge
            if (res.res_valid && !res.res_ready)
              overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn_window_decoder.sv
// Directed self-checking bench for sn_window_decoder (WIN_LOG2=4).
// Inputs change on falling edges; outputs sampled on falling edges.
module tb_sn_window_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic sn_bit = 1'b0;
  logic sn_valid = 1'b0;
  logic overrun;
  logic busy;

  int checks = 0;
  int errors = 0;

  sn_window_decoder_if #(.WIN_LOG2(4)) rif ();

  sn_window_decoder #(.WIN_LOG2(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .sn_bit   (sn_bit),
    .sn_valid (sn_valid),
    .res      (rif),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input int n, input int k, input bit alt);
    for (int i = 0; i < n; i++) begin
      sn_valid = 1'b1;
      sn_bit   = alt ? (i % 2 == 0) : (i < k);
      tick();
    end
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
  endtask

  task automatic ack();
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
  endtask

  function automatic int bip();
    return int'(rif.res_bipolar);
  endfunction

  initial begin
    rif.res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("rst_valid", int'(rif.res_valid), 0);
    chk("rst_count", int'(rif.res_count), 0);
    chk("rst_bip", bip(), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);

    // 1: all ones window
    enable = 1'b1;
    tick();
    chk("t1_busy", int'(busy), 1);
    feed(15, 15, 1'b0);
    chk("t1_early", int'(rif.res_valid), 0);
    feed(1, 1, 1'b0);
    chk("t1_valid", int'(rif.res_valid), 1);
    chk("t1_count", int'(rif.res_count), 16);
    chk("t1_bip", bip(), 16);
    chk("t1_ovr", int'(overrun), 0);
    tick();
    chk("t1_hold", int'(rif.res_count), 16);

    // 2: alternating, then all zeros
    ack();
    chk("t2_ack", int'(rif.res_valid), 0);
    feed(16, 0, 1'b1);
    chk("t2a_valid", int'(rif.res_valid), 1);
    chk("t2a_count", int'(rif.res_count), 8);
    chk("t2a_bip", bip(), 0);
    ack();
    feed(16, 0, 1'b0);
    chk("t2b_count", int'(rif.res_count), 0);
    chk("t2b_bip", bip(), -16);

    // 3: sn_valid toggles, 32 cycles for 16 bits
    ack();
    sn_bit = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sn_valid = (i % 2 == 1);
      if (i == 31) chk("t3_early", int'(rif.res_valid), 0);
      tick();
    end
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
    chk("t3_valid", int'(rif.res_valid), 1);
    chk("t3_count", int'(rif.res_count), 16);

    // 4: overrun across two windows, then clear
    ack();
    feed(16, 12, 1'b0);
    chk("t4a_count", int'(rif.res_count), 12);
    chk("t4a_ovr", int'(overrun), 0);
    feed(16, 4, 1'b0);
    chk("t4b_count", int'(rif.res_count), 4);
    chk("t4b_bip", bip(), -8);
    chk("t4b_ovr", int'(overrun), 1);
    chk("t4b_valid", int'(rif.res_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4c_valid", int'(rif.res_valid), 0);
    chk("t4c_ovr", int'(overrun), 0);
    chk("t4c_keep", int'(rif.res_count), 4);
    chk("t4c_busy", int'(busy), 0);

    // 5: ready on the completion edge of window 2
    tick();
    feed(16, 16, 1'b0);
    chk("t5a_count", int'(rif.res_count), 16);
    feed(15, 0, 1'b0);
    rif.res_ready = 1'b1;
    feed(1, 0, 1'b0);
    rif.res_ready = 1'b0;
    chk("t5_valid", int'(rif.res_valid), 1);
    chk("t5_count", int'(rif.res_count), 0);
    chk("t5_bip", bip(), -16);
    chk("t5_ovr", int'(overrun), 0);

    // clear on the completion edge wins
    ack();
    feed(15, 15, 1'b0);
    clear = 1'b1;
    feed(1, 1, 1'b0);
    clear = 1'b0;
    chk("clr_done_valid", int'(rif.res_valid), 0);
    chk("clr_done_count", int'(rif.res_count), 0);

    // 6: abort after 7 bits, then full window
    tick();
    feed(7, 7, 1'b0);
    enable = 1'b0;
    tick();
    chk("t6_idle", int'(busy), 0);
    enable = 1'b1;
    tick();
    feed(15, 15, 1'b0);
    chk("t6_early", int'(rif.res_valid), 0);
    feed(1, 1, 1'b0);
    chk("t6_valid", int'(rif.res_valid), 1);
    chk("t6_count", int'(rif.res_count), 16);

    // reset mid-window at bit 9
    ack();
    feed(9, 9, 1'b0);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("t6r_count", int'(rif.res_count), 0);
    chk("t6r_bip", bip(), 0);
    chk("t6r_valid", int'(rif.res_valid), 0);
    chk("t6r_ovr", int'(overrun), 0);
    chk("t6r_busy", int'(busy), 0);
    tick();
    feed(15, 4, 1'b0);
    chk("t6r_early", int'(rif.res_valid), 0);
    feed(1, 0, 1'b0);
    chk("t6r_count2", int'(rif.res_count), 4);
    chk("t6r_bip2", bip(), -8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
